regfile_mp: RTL

//  Parametrised multi-port CPU register file with a per-register pending (scoreboard) bit.

---
 rtl/regfile_mp_pkg.sv | 27 ++
 rtl/regfile_mp_sb.sv | 51 +++++
 rtl/regfile_mp.sv | 83 ++++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Zero latency, no backpressure. Used by regfile_mp and regfile_mp_sb.
package regfile_mp_pkg;

  localparam int DW_DEFAULT     = 32;
  localparam int DEPTH_DEFAULT  = 32;
  localparam int NUM_RD_DEFAULT = 2;
  localparam int NUM_WR_DEFAULT = 1;

  // Widest pending vector popcount() accepts; callers zero-extend into it.
  localparam int POP_MAX = 1024;

  // Never returns less than 1, so a 2-entry file still gets a 1-bit address.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int popcount(input logic [POP_MAX-1:0] v);
    int c;
    c = 0;
    for (int k = 0; k < POP_MAX; k++) begin
      c += int'(v[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Scoreboard: one pending bit per register plus a population count of them.
// Updates on posedge; reserve beats a same-cycle write to the same register. No backpressure.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int NUM_WR   = NUM_WR_DEFAULT,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2_safe(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [DEPTH-1:0]     pend,
  output logic [AW:0]          pend_cnt
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_nxt;

  always_comb begin
    pend_nxt = pend_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        pend_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    // Applied after the clears: a newly issued producer supersedes the result landing now.
    if (rsv_en) begin
      pend_nxt[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pend_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = (AW+1)'(popcount(POP_MAX'(pend_q)));

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending bits; combinational reads, writes at posedge, no backpressure.
// Defining REGFILE_MP_BYPASS_EN forwards same-cycle write data and pending state to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int NUM_RD   = NUM_RD_DEFAULT,
  parameter int NUM_WR   = NUM_WR_DEFAULT,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2_safe(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [AW:0]          pend_cnt
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;

  regfile_mp_sb #(
    .DEPTH    (DEPTH),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend     (pend),
    .pend_cnt (pend_cnt)
  );

  // Ports are visited in ascending order, so the last non-blocking write (highest port) wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0)) begin
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DW +: DW] = mem[rd_addr[i*AW +: AW]];
      rd_busy[i]          = pend[rd_addr[i*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) begin
          rd_data[i*DW +: DW] = wr_data[j*DW +: DW];
          rd_busy[i]          = 1'b0;
        end
      end
      if (rsv_en && rsv_addr == rd_addr[i*AW +: AW]) begin
        rd_busy[i] = 1'b1;
      end
`endif
      if (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0) begin
        rd_data[i*DW +: DW] = '0;
        rd_busy[i]          = 1'b0;
      end
    end
  end

endmodule
